// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline control slice:
//   - bit positions of each pipeline register in the hold/flush vectors
//   - FSM state encodings for pipe_ctrl
//   - helper to build a contiguous stage mask
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // Bit index of each pipeline register in hold_o / flush_o.
    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;
    localparam int NUM_STG    = 5;

    // Controller states.
    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DIV_BUSY   = 2'd1,
        ST_REDIR_PEND = 2'd2
    } state_e;

    // Mask with bits lo..hi (inclusive) set; used to express "hold every
    // register from the PC up to stage X" without hand-written constants.
    function automatic logic [NUM_STG-1:0] stg_range(input int lo, input int hi);
        logic [NUM_STG-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_STG; i++) begin
            if (i >= lo && i <= hi) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipe_stall_cnt.sv
// -----------------------------------------------------------------------------
// pipe_stall_cnt
// Saturating event counter: counts clocks on which inc_i is high and sticks at
// all-ones instead of wrapping.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset, clears the count
//   inc_i  - count this clock
//   cnt_o  - current count (CNT_W bits)
// -----------------------------------------------------------------------------
module pipe_stall_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (inc_i && !(&cnt_reg)) begin
            cnt_reg <= cnt_reg + ONE;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Five-stage pipeline hazard controller. Resolves per-register hold/flush,
// PC redirect and a stall counter from the hazard inputs and a small FSM that
// tracks multi-cycle divides and redirects deferred by a data-memory stall.
// Ports:
//   clk, rst_n     - clock (rising edge), asynchronous active-low reset
//   dmem_wait_i    - MEM stage cannot retire
//   div_start_i    - EX issues a multi-cycle divide (pulse)
//   div_done_i     - divider result valid this cycle
//   jump_i         - EX resolved a taken branch/jump
//   jump_addr_i    - redirect target (XLEN)
//   ld_use_i       - load-use hazard in ID
//   imem_wait_i    - instruction fetch not ready
//   hold_o         - per-register hold  (bit0 pc .. bit4 mem_wb)
//   flush_o        - per-register bubble insert, same map
//   redirect_o     - PC loads target_o this cycle
//   target_o       - redirect address
//   busy_o         - FSM not in RUN
//   stall_cnt_o    - clocks with any hold bit set (saturating)
// -----------------------------------------------------------------------------
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dmem_wait_i,
    input  logic               div_start_i,
    input  logic               div_done_i,
    input  logic               jump_i,
    input  logic [XLEN-1:0]    jump_addr_i,
    input  logic               ld_use_i,
    input  logic               imem_wait_i,
    output logic [NUM_STG-1:0] hold_o,
    output logic [NUM_STG-1:0] flush_o,
    output logic               redirect_o,
    output logic [XLEN-1:0]    target_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    state_e          state_reg, state_next;
    logic [XLEN-1:0] target_reg, target_next;

    logic            div_hold;
    logic            redir_pend;

    // A divide keeps EX occupied until the cycle its result appears; the
    // done cycle itself lets the pipe advance.
    assign div_hold   = ((state_reg == ST_DIV_BUSY) || div_start_i) && !div_done_i;
    // jump_i only counts in RUN: during a divide EX is frozen, and in
    // REDIR_PEND the original target has already been captured.
    assign redir_pend = ((state_reg == ST_RUN) && jump_i) || (state_reg == ST_REDIR_PEND);

    // Priority resolution; only the winning hazard drives any control bit.
    always_comb begin
        hold_o     = '0;
        flush_o    = '0;
        redirect_o = 1'b0;
        if (dmem_wait_i) begin
            hold_o              = stg_range(STG_PC, STG_EX_MEM);
            flush_o[STG_MEM_WB] = 1'b1;
        end else if (div_hold) begin
            hold_o              = stg_range(STG_PC, STG_ID_EX);
            flush_o[STG_EX_MEM] = 1'b1;
        end else if (redir_pend) begin
            redirect_o          = 1'b1;
            flush_o[STG_IF_ID]  = 1'b1;
            flush_o[STG_ID_EX]  = 1'b1;
        end else if (ld_use_i) begin
            hold_o              = stg_range(STG_PC, STG_IF_ID);
            flush_o[STG_ID_EX]  = 1'b1;
        end else if (imem_wait_i) begin
            hold_o              = stg_range(STG_PC, STG_PC);
            flush_o[STG_IF_ID]  = 1'b1;
        end
    end

    // Next-state logic. A divide start is tracked even when a memory stall
    // wins the cycle, otherwise the divide would be forgotten.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        case (state_reg)
            ST_RUN: begin
                if (div_start_i && !div_done_i) begin
                    state_next = ST_DIV_BUSY;
                end else if (jump_i && dmem_wait_i) begin
                    state_next  = ST_REDIR_PEND;
                    target_next = jump_addr_i;
                end
            end
            ST_DIV_BUSY: begin
                if (div_done_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_REDIR_PEND: begin
                // Leave only once the redirect has actually been issued.
                if (redirect_o) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_RUN;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    assign target_o = (state_reg == ST_REDIR_PEND) ? target_reg : jump_addr_i;
    assign busy_o   = (state_reg != ST_RUN);

    pipe_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (|hold_o),
        .cnt_o (stall_cnt_o)
    );

endmodule
